signed_block_accumulator: RTL and testbench
===========================================

# signed_block_accumulator

Accumulates blocks of `ACC_LEN` signed 2's-complement samples, adding or subtracting each sample per a per-sample sign select. It sits directly downstream of the sign inversion stage in the interpolator datapath and absorbs its add/subtract role, with a widened, saturating datapath. Input and output use valid/ready handshakes. One result is emitted per completed block.

## Interface
Parameters:
- `DATA_WIDTH`, 12: input sample width, 2's complement.
- `ACC_WIDTH`, 16: accumulator/result width; must be ≥ `DATA_WIDTH`.
- `ACC_LEN`, 4: samples per block; ≥ 2.

Ports:
- `clk_i`  in  1  single clock; all logic on rising edge.
- `rstn_i`  in  1  reset, synchronous, active-low.
- `clear_i`  in  1  synchronous abort of current block.
- `data_i`  in  `DATA_WIDTH`  input sample.
- `sub_i`  in  1  1: subtract `data_i`; 0: add. Sampled with `data_i`.
- `valid_i`  in  1  input sample valid.
- `ready_o`  out  1  block can accept a sample.
- `data_o`  out  `ACC_WIDTH`  block result, 2's complement.
- `sat_o`  out  1  result was clipped at least once during the block.
- `valid_o`  out  1  `data_o`/`sat_o` valid.
- `ready_i`  in  1  downstream accepts the result.

## Operation
- There are two states, ACCUM and HOLD. Reset state is ACCUM. `ready_o` = (state == ACCUM).
- An input accept occurs when `valid_i && ready_o` is high at a clock edge.
- ACCUM, on each accept:
  - `acc <= sat(acc ± sext(data_i))`.
  - `cnt <= cnt + 1`.
  - `sat_flag` is set if clipping occurred.
- ACCUM, on the accept with `cnt == ACC_LEN-1`:
  - `data_o` loads the saturated final sum.
  - `sat_o` loads `sat_flag` OR'd with this step's clip.
  - `valid_o` goes to 1, and the state moves to HOLD.
  - `acc`, `cnt` and `sat_flag` are cleared.
- HOLD:
  - `ready_o` = 0; `valid_i` is ignored.
  - `data_o` and `sat_o` stay stable.
  - On `valid_o && ready_i`, `valid_o` goes to 0 and the state moves to ACCUM.
- Arithmetic:
  - `data_i` is sign-extended to `ACC_WIDTH+1` bits before negation or addition, so −(−2^(DATA_WIDTH−1)) is exact (no wrap).
  - The result is clipped to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
- Priority, highest first: `rstn_i` low > `clear_i` > handshake.
  - `rstn_i` low at an edge: state ← ACCUM; `acc`, `cnt`, `sat_flag`, `data_o`, `sat_o`, `valid_o` ← 0.
  - `clear_i` high at an edge: same effect as reset. Any sample offered on that edge is discarded, and a pending HOLD result is dropped.
- Reset values: `data_o` = 0, `sat_o` = 0, `valid_o` = 0, `ready_o` = 1.
- `valid_i` gaps are allowed. A partial block is held indefinitely.

## Timing
- Latency: `valid_o` rises on the edge of the `ACC_LEN`-th accept and is visible in the following cycle.
- Throughput: at most one block per `ACC_LEN+1` cycles, because one cycle is spent in HOLD even when `ready_i` is held high.
- `ready_o` is decoded from registered state only; there is no combinational path from `ready_i` or `valid_i`.
- `data_o`, `sat_o` and `valid_o` are registered outputs.
- Reset mid-block or in HOLD: the next cycle shows the reset values; the partial sum is lost.
- `ready_i` high while `valid_o` is 0 has no effect.

## Structure
- Shared package `intpol_pkg` holds:
  - the state encoding constants `ST_ACCUM` and `ST_HOLD`;
  - a saturation limit function for a given width.
- Sub-module `sat_addsub`: combinational, `ACC_WIDTH` accumulator ± sign-extended `DATA_WIDTH` operand. It outputs the clipped sum and a clip flag.
- Top level: FSM, counter of width $clog2(`ACC_LEN`), and output registers.

## Test plan
- Defaults: inputs 100, 200, −50 (`sub_i` = 0), then 30 (`sub_i` = 1), `ready_i` = 1.
  - Expect `data_o` = 220, `sat_o` = 0, `valid_o` for exactly 1 cycle.
  - Expect `ready_o` = 0 for 1 cycle, then back to 1.
- Input −2048 with `sub_i` = 1, four times → `data_o` = 8192, `sat_o` = 0 (exact negation of the most negative value).
- `ACC_LEN` = 32, input 2047 × 32 → `data_o` = 32767, `sat_o` = 1. Next block of 1 × 32 → `data_o` = 32, `sat_o` = 0.
- Backpressure: `ready_i` = 0 for 5 cycles after `valid_o` rises, with `valid_i` = 1 throughout.
  - `data_o` stays stable and `ready_o` stays 0; no samples are consumed.
  - `ready_i` = 1 → `valid_o` drops the next cycle.
- `clear_i` pulse after 2 accepted samples (500, 500), then 1, 2, 3, 4 → `data_o` = 10.
- `rstn_i` low for 1 cycle during HOLD → next cycle `valid_o` = 0, `data_o` = 0, `ready_o` = 1. A subsequent block sums correctly.

Source files
------------

// File: rtl/intpol_pkg.sv
// Shared interpolator definitions: accumulator FSM state encoding and
// two's-complement saturation limits for an arbitrary width.
package intpol_pkg;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } acc_state_e;

    // Largest positive value representable in a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_max(input int width);
        return (64'sd1 <<< (width - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a signed field of 'width' bits.
    function automatic logic signed [63:0] sat_min(input int width);
        return -(64'sd1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/signed_block_accumulator_sat_addsub.sv
// Saturating accumulator step: acc +/- sign-extended sample, clipped to ACC_WIDTH.
// Latency: combinational, zero cycles.
// Backpressure: none, pure datapath.
module sat_addsub
    import intpol_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ACC_WIDTH  = 16
) (
    input  logic [ACC_WIDTH-1:0]  acc_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sub_i,
    output logic [ACC_WIDTH-1:0]  sum_o,
    output logic                  clip_o
);

    localparam logic signed [ACC_WIDTH:0] MAX_V = (ACC_WIDTH + 1)'(sat_max(ACC_WIDTH));
    localparam logic signed [ACC_WIDTH:0] MIN_V = (ACC_WIDTH + 1)'(sat_min(ACC_WIDTH));

    logic signed [ACC_WIDTH:0] acc_ext;
    logic signed [ACC_WIDTH:0] opd_ext;
    logic signed [ACC_WIDTH:0] opd_sgn;
    logic signed [ACC_WIDTH:0] sum_ext;

    // One guard bit is enough: |acc +/- sample| never exceeds 2^ACC_WIDTH,
    // and negating the most negative sample stays exact.
    always_comb begin
        acc_ext = {acc_i[ACC_WIDTH-1], acc_i};
        opd_ext = {{(ACC_WIDTH + 1 - DATA_WIDTH){data_i[DATA_WIDTH-1]}}, data_i};
        opd_sgn = sub_i ? -opd_ext : opd_ext;
        sum_ext = acc_ext + opd_sgn;
        clip_o  = 1'b0;
        sum_o   = sum_ext[ACC_WIDTH-1:0];
        if (sum_ext > MAX_V) begin
            sum_o  = MAX_V[ACC_WIDTH-1:0];
            clip_o = 1'b1;
        end else if (sum_ext < MIN_V) begin
            sum_o  = MIN_V[ACC_WIDTH-1:0];
            clip_o = 1'b1;
        end
    end

endmodule

// File: rtl/signed_block_accumulator.sv
// Sums blocks of ACC_LEN signed samples (add/sub per sample) with saturation.
// Latency: result registered on the ACC_LEN-th accept, visible next cycle.
// Backpressure: ready_o low while a result is held; held until ready_i.
module signed_block_accumulator
    import intpol_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int ACC_WIDTH  = 16,
    parameter int ACC_LEN    = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  sub_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [ACC_WIDTH-1:0]  data_o,
    output logic                  sat_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int               CNT_W    = $clog2(ACC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

    acc_state_e           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sat_flag_q, sat_flag_d;
    logic [ACC_WIDTH-1:0] data_q, data_d;
    logic                 sat_q, sat_d;
    logic                 valid_q, valid_d;

    logic [ACC_WIDTH-1:0] step_sum;
    logic                 step_clip;
    logic                 in_xfer;
    logic                 out_xfer;

    sat_addsub #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH)
    ) u_sat_addsub (
        .acc_i  (acc_q),
        .data_i (data_i),
        .sub_i  (sub_i),
        .sum_o  (step_sum),
        .clip_o (step_clip)
    );

    assign ready_o  = (state_q == ST_ACCUM);
    assign in_xfer  = valid_i && ready_o;
    assign out_xfer = valid_q && ready_i;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        sat_flag_d = sat_flag_q;
        data_d     = data_q;
        sat_d      = sat_q;
        valid_d    = valid_q;

        if (clear_i) begin
            state_d    = ST_ACCUM;
            acc_d      = '0;
            cnt_d      = '0;
            sat_flag_d = 1'b0;
            data_d     = '0;
            sat_d      = 1'b0;
            valid_d    = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (in_xfer) begin
                        if (cnt_q == LAST_CNT) begin
                            data_d     = step_sum;
                            sat_d      = sat_flag_q | step_clip;
                            valid_d    = 1'b1;
                            state_d    = ST_HOLD;
                            acc_d      = '0;
                            cnt_d      = '0;
                            sat_flag_d = 1'b0;
                        end else begin
                            acc_d      = step_sum;
                            cnt_d      = cnt_q + CNT_W'(1);
                            sat_flag_d = sat_flag_q | step_clip;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_xfer) begin
                        valid_d = 1'b0;
                        state_d = ST_ACCUM;
                    end
                end
                default: state_d = ST_ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= ST_ACCUM;
            acc_q      <= '0;
            cnt_q      <= '0;
            sat_flag_q <= 1'b0;
            data_q     <= '0;
            sat_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            sat_flag_q <= sat_flag_d;
            data_q     <= data_d;
            sat_q      <= sat_d;
            valid_q    <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign sat_o   = sat_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_signed_block_accumulator.sv
// Randomized and directed checks of two accumulator instances (ACC_LEN 4 and 32)
// against a block-level reference model.
module tb_signed_block_accumulator;

    localparam int DW   = 12;
    localparam int AW   = 16;
    localparam int LEN0 = 4;
    localparam int LEN1 = 32;
    localparam int AMAX = 32767;
    localparam int AMIN = -32768;

    logic          clk;
    logic          rstn;
    logic          clr  [2];
    logic [DW-1:0] din  [2];
    logic          sub  [2];
    logic          vin  [2];
    logic          rin  [2];
    logic          rdy  [2];
    logic [AW-1:0] dout [2];
    logic          sat  [2];
    logic          vout [2];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    signed_block_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ACC_LEN(LEN0)) dut0 (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clr[0]), .data_i(din[0]), .sub_i(sub[0]),
        .valid_i(vin[0]), .ready_o(rdy[0]), .data_o(dout[0]), .sat_o(sat[0]),
        .valid_o(vout[0]), .ready_i(rin[0])
    );

    signed_block_accumulator #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ACC_LEN(LEN1)) dut1 (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clr[1]), .data_i(din[1]), .sub_i(sub[1]),
        .valid_i(vin[1]), .ready_o(rdy[1]), .data_o(dout[1]), .sat_o(sat[1]),
        .valid_o(vout[1]), .ready_i(rin[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input int inst, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0d, expected %0d at %0t", nm, inst, act, exp, $time);
        end
    endfunction

    function automatic int len_of(input int i);
        return (i == 0) ? LEN0 : LEN1;
    endfunction

    // Reference model: collect the signed contributions of a block, then
    // replay them with clipping after every step once the block is complete.
    int m_buf  [2][LEN1];
    int m_n    [2];
    bit m_hold [2];
    int m_dat  [2];
    bit m_sat  [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_n[i] = 0; m_hold[i] = 0; m_dat[i] = 0; m_sat[i] = 0;
        end
    end

    function automatic void block_result(input int i);
        int  acc = 0;
        bit  s   = 0;
        for (int j = 0; j < len_of(i); j++) begin
            acc += m_buf[i][j];
            if (acc > AMAX) begin acc = AMAX; s = 1; end
            else if (acc < AMIN) begin acc = AMIN; s = 1; end
        end
        m_dat[i] = acc;
        m_sat[i] = s;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rstn || clr[i]) begin
                m_n[i] = 0; m_hold[i] = 0; m_dat[i] = 0; m_sat[i] = 0;
            end else if (m_hold[i]) begin
                if (rin[i]) m_hold[i] = 0;
            end else if (vin[i]) begin
                m_buf[i][m_n[i]] = sub[i] ? -int'($signed(din[i])) : int'($signed(din[i]));
                m_n[i]++;
                if (m_n[i] == len_of(i)) begin
                    block_result(i);
                    m_n[i]    = 0;
                    m_hold[i] = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("ready_o", i, int'(rdy[i]), int'(!m_hold[i]));
                check("valid_o", i, int'(vout[i]), int'(m_hold[i]));
                check("data_o", i, int'($signed(dout[i])), m_dat[i]);
                check("sat_o", i, int'(sat[i]), int'(m_sat[i]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input int v, input bit s);
        int k = 0;
        din[i] = DW'(v);
        sub[i] = s;
        vin[i] = 1'b1;
        while (!rdy[i] && k < 200) begin
            step();
            k++;
        end
        if (k >= 200) check("send_timeout", i, k, 0);
        step();
        vin[i] = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            clr[i] = 0; din[i] = '0; sub[i] = 0; vin[i] = 0; rin[i] = 1;
        end
        step();
        chk_en = 1;
        step();
        check("rst_ready", 0, int'(rdy[0]), 1);
        check("rst_valid", 0, int'(vout[0]), 0);
        check("rst_data", 0, int'(dout[0]), 0);
        rstn = 1'b1;
        step();

        // Mixed add/sub block: 100 + 200 - 50 - 30
        send(0, 100, 0); send(0, 200, 0); send(0, -50, 0); send(0, 30, 1);
        check("t1_valid", 0, int'(vout[0]), 1);
        check("t1_data", 0, int'($signed(dout[0])), 220);
        check("t1_sat", 0, int'(sat[0]), 0);
        check("t1_ready", 0, int'(rdy[0]), 0);
        step();
        check("t1_valid_drop", 0, int'(vout[0]), 0);
        check("t1_ready_back", 0, int'(rdy[0]), 1);

        // Exact negation of the most negative sample
        for (int n = 0; n < 4; n++) send(0, -2048, 1);
        check("neg_data", 0, int'($signed(dout[0])), 8192);
        check("neg_sat", 0, int'(sat[0]), 0);
        step();

        // Backpressure: result held while valid_i stays high
        rin[0] = 1'b0;
        send(0, 10, 0); send(0, 20, 0); send(0, 30, 0); send(0, 40, 0);
        din[0] = DW'(999);
        vin[0] = 1'b1;
        for (int n = 0; n < 5; n++) begin
            check("bp_valid", 0, int'(vout[0]), 1);
            check("bp_data", 0, int'($signed(dout[0])), 100);
            check("bp_ready", 0, int'(rdy[0]), 0);
            step();
        end
        rin[0] = 1'b1;
        step();
        vin[0] = 1'b0;
        check("bp_release", 0, int'(vout[0]), 0);
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
        check("bp_next_data", 0, int'($signed(dout[0])), 10);

        // Clear drops a partial block and the sample offered with it
        send(0, 500, 0); send(0, 500, 0);
        clr[0] = 1'b1; din[0] = DW'(7); vin[0] = 1'b1;
        step();
        clr[0] = 1'b0; vin[0] = 1'b0;
        send(0, 1, 0); send(0, 2, 0); send(0, 3, 0); send(0, 4, 0);
        check("clr_data", 0, int'($signed(dout[0])), 10);
        step();

        // Reset during HOLD
        rin[0] = 1'b0;
        send(0, 5, 0); send(0, 5, 0); send(0, 5, 0); send(0, 5, 0);
        check("hold_valid", 0, int'(vout[0]), 1);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        check("rst_hold_valid", 0, int'(vout[0]), 0);
        check("rst_hold_data", 0, int'(dout[0]), 0);
        check("rst_hold_ready", 0, int'(rdy[0]), 1);
        rin[0] = 1'b1;
        send(0, 5, 0); send(0, 6, 0); send(0, 7, 0); send(0, 8, 0);
        check("post_rst_data", 0, int'($signed(dout[0])), 26);

        // Long block saturates, following block is clean
        for (int n = 0; n < LEN1; n++) send(1, 2047, 0);
        check("sat32_data", 1, int'($signed(dout[1])), 32767);
        check("sat32_flag", 1, int'(sat[1]), 1);
        for (int n = 0; n < LEN1; n++) send(1, 1, 0);
        check("ones32_data", 1, int'($signed(dout[1])), 32);
        check("ones32_flag", 1, int'(sat[1]), 0);
        step();

        // Randomized traffic on both instances
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                vin[i] = ($urandom_range(0, 3) != 0);
                sub[i] = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       din[i] = 12'h800;
                    1:       din[i] = 12'h7FF;
                    default: din[i] = 12'($urandom);
                endcase
                rin[i] = ($urandom_range(0, 2) != 0);
                clr[i] = ($urandom_range(0, 80) == 0);
            end
            rstn = ($urandom_range(0, 400) != 0);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            vin[i] = 0; clr[i] = 0; rin[i] = 1;
        end
        rstn = 1'b1;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
